// File: rtl/skid_reg_if.sv
// Handshake bundle for skid_reg: upstream valid/ready/data, downstream valid/ready/data,
// plus occupancy. The stage itself connects through the slave modport.
interface skid_reg_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       level;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/skid_reg.sv
// Two-entry skid buffer: main register drives the output, skid register absorbs
// the word launched upstream before in_ready drops. All outputs decode from flops.
module skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  skid_reg_if.slave  bus
);

  // Encoding chosen so the state register is the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             in_xfer;
  logic             out_xfer;

  assign bus.out_valid = (state_q != EMPTY);
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_data  = m_q;
  assign bus.level     = state_q;

  assign in_xfer  = bus.in_valid  & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          m_d     = bus.in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          m_d = bus.in_data;
        end else if (in_xfer) begin
          s_d     = bus.in_data;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_skid_reg.sv
// Directed and randomized checks of skid_reg against hand-computed values and a
// queue scoreboard.
module tb_skid_reg;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [7:0] sb[$];

  skid_reg_if #(.WIDTH(8)) bus ();

  skid_reg #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_level"},     32'(bus.level),     32'd0);
    chk({tag, "_out_data"},  32'(bus.out_data),  32'h00);
  endtask

  initial begin
    logic in_x;
    logic out_x;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    #2;
    chk_reset("por");
    step();
    step();
    rst_n = 1'b1;

    // Single word
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hFF;
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data",  32'(bus.out_data),  32'hA5);
    chk("single_lvl1",  32'(bus.level),     32'd1);
    step();
    chk("single_gone",  32'(bus.out_valid), 32'd0);
    chk("single_lvl0",  32'(bus.level),     32'd0);

    // Fill and backpressure
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    step();
    chk("fill1_lvl",   32'(bus.level),    32'd1);
    chk("fill1_data",  32'(bus.out_data), 32'h11);
    chk("fill1_ready", 32'(bus.in_ready), 32'd1);
    bus.in_data = 8'h22;
    step();
    chk("fill2_lvl",   32'(bus.level),    32'd2);
    chk("fill2_data",  32'(bus.out_data), 32'h11);
    chk("fill2_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data = 8'h33;
    step();
    chk("fill3_lvl",   32'(bus.level),    32'd2);
    chk("fill3_data",  32'(bus.out_data), 32'h11);
    chk("fill3_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("fill4_data",  32'(bus.out_data), 32'h11);

    // Drain with 0x33 still offered
    bus.out_ready = 1'b1;
    chk("drain0_data", 32'(bus.out_data), 32'h11);
    step();
    chk("drain1_data",  32'(bus.out_data), 32'h22);
    chk("drain1_ready", 32'(bus.in_ready), 32'd1);
    chk("drain1_lvl",   32'(bus.level),    32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("drain2_data",  32'(bus.out_data),  32'h33);
    chk("drain2_valid", 32'(bus.out_valid), 32'd1);
    step();
    chk("drain3_valid", 32'(bus.out_valid), 32'd0);
    chk("drain3_lvl",   32'(bus.level),     32'd0);

    // Streaming 0x00..0x0F
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data   = 8'h00;
    step();
    for (int i = 1; i <= 16; i++) begin
      chk("stream_lvl",   32'(bus.level),     32'd1);
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_data",  32'(bus.out_data),  32'(i - 1));
      if (i == 16) bus.in_valid = 1'b0;
      bus.in_data = 8'(i);
      step();
    end
    chk("stream_end_lvl", 32'(bus.level), 32'd0);

    // Asynchronous reset mid-clock while FULL
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    step();
    bus.in_data = 8'hC3;
    step();
    chk("prerst_lvl", 32'(bus.level), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    step();
    chk("rst_hold_lvl", 32'(bus.level), 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step();
    chk("postrst_lvl", 32'(bus.level), 32'd0);

    // Random stress against a scoreboard
    for (int c = 0; c < 1000; c++) begin
      chk("rnd_lvl",   32'(bus.level),     32'(sb.size()));
      chk("rnd_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      chk("rnd_ready", 32'(bus.in_ready),  32'(sb.size() < 2));
      if (sb.size() != 0) chk("rnd_data", 32'(bus.out_data), 32'(sb[0]));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      in_x  = bus.in_valid && (sb.size() < 2);
      out_x = bus.out_ready && (sb.size() != 0);
      step();
      if (out_x) void'(sb.pop_front());
      if (in_x) sb.push_back(bus.in_data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
